// File: rtl/dmi_responder_if.sv
// DMI request/response channel pair between an initiator (master) and a debug-module responder (slave).
// Both channels use valid/ready: a transfer happens at a rising edge where valid and ready are both high.
interface dmi_responder_if;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_rsp_valid;
    logic        dmi_rsp_ready;
    logic [31:0] dmi_rsp_data;
    logic [1:0]  dmi_rsp_response;

    modport master (
        output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready,
        input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_response
    );

    modport slave (
        input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready,
        output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_response
    );
endinterface

// File: rtl/dmi_responder.sv
// DMI target stand-in: executes one request at a time against a small register window
// and answers after a fixed programmable latency. Address 7'h7F reads the request counter.
module dmi_responder #(
    parameter logic [6:0]  BASE_ADDR = 7'h04,
    parameter int unsigned NREGS     = 16,
    parameter int unsigned LATENCY   = 2
) (
    input  logic           CLK,
    input  logic           RST,
    dmi_responder_if.slave dmi,
    output logic [1:0]     state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [7:0]  NREGS_8  = 8'(NREGS);
    localparam logic [7:0]  LAT_INIT = 8'(LATENCY);
    localparam logic [6:0]  CNT_ADDR = 7'h7F;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic [7:0]  lat_q, lat_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] regs_q [NREGS];

    logic             accept;
    logic             in_win;
    logic             wr_en;
    logic [7:0]       off;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_win;

    assign accept = dmi.dmi_req_valid && req_ready_q && (state_q == S_IDLE);
    assign off    = {1'b0, dmi.dmi_req_addr} - {1'b0, BASE_ADDR};
    assign in_win = (dmi.dmi_req_addr >= BASE_ADDR) && (off < NREGS_8);
    assign idx    = off[IDX_W-1:0];
    assign rd_win = regs_q[idx];

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d      = cnt_q + 32'd1;
                    lat_d      = LAT_INIT;
                    state_d    = (LATENCY == 0) ? S_RESP : S_WAIT;
                    rsp_data_d = 32'd0;
                    rsp_resp_d = 2'd0;
                    case (dmi.dmi_req_op)
                        2'd1: begin
                            // Counter read returns the value before this request's own increment.
                            if (in_win) rsp_data_d = rd_win;
                            else if (dmi.dmi_req_addr == CNT_ADDR) rsp_data_d = cnt_q;
                        end
                        2'd2:    wr_en = in_win;
                        2'd3:    rsp_resp_d = 2'd2;
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 8'd1;
                if (lat_q <= 8'd1) state_d = S_RESP;
            end
            S_RESP: begin
                // Valid rises one cycle after entering RESP, giving LATENCY+1 cycles overall.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (dmi.dmi_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_resp_q  <= 2'd0;
            lat_q       <= 8'd0;
            cnt_q       <= 32'd0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            lat_q       <= lat_d;
            cnt_q       <= cnt_d;
            if (wr_en) regs_q[idx] <= dmi.dmi_req_data;
        end
    end

    assign dmi.dmi_req_ready    = req_ready_q;
    assign dmi.dmi_rsp_valid    = rsp_valid_q;
    assign dmi.dmi_rsp_data     = rsp_data_q;
    assign dmi.dmi_rsp_response = rsp_resp_q;
    assign state_o              = state_q;

endmodule

// File: tb/tb_dmi_responder.sv
// Self-checking bench for dmi_responder: a reference model pushes expected responses
// into a queue at acceptance; responses are popped and compared when the DUT presents them.
module tb_dmi_responder;

    localparam int         LAT   = 2;
    localparam int         NREGS = 16;
    localparam logic [6:0] BASE  = 7'h04;

    logic       CLK;
    logic       RST;
    logic [1:0] state_o;

    dmi_responder_if dmi_if ();

    dmi_responder #(.BASE_ADDR(BASE), .NREGS(NREGS), .LATENCY(LAT)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .dmi    (dmi_if),
        .state_o(state_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_resp_q[$];
    logic [31:0] m_regs [NREGS];
    logic [31:0] m_cnt;

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        exp_data_q.delete();
        exp_resp_q.delete();
    endtask

    task automatic model_push(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic [1:0]  r;
        bit          win;
        d   = 32'd0;
        r   = 2'd0;
        win = (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + NREGS);
        case (op)
            2'd1: begin
                if (win) d = m_regs[int'(addr) - int'(BASE)];
                else if (addr == 7'h7F) d = m_cnt;
            end
            2'd2: if (win) m_regs[int'(addr) - int'(BASE)] = data;
            2'd3: r = 2'd2;
            default: ;
        endcase
        m_cnt = m_cnt + 32'd1;
        exp_data_q.push_back(d);
        exp_resp_q.push_back(r);
    endtask

    task automatic idle_inputs();
        dmi_if.dmi_req_valid = 1'b0;
        dmi_if.dmi_req_addr  = 7'd0;
        dmi_if.dmi_req_data  = 32'd0;
        dmi_if.dmi_req_op    = 2'd0;
        dmi_if.dmi_rsp_ready = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        RST = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        model_reset();
        @(posedge CLK); #1;
    endtask

    // Drive one request and return once it has been accepted (at #1 after the accepting edge).
    task automatic do_req(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        int k;
        k = 0;
        while (!dmi_if.dmi_req_ready && k < 40) begin
            @(posedge CLK); #1;
            k++;
        end
        n_checks++;
        if (!dmi_if.dmi_req_ready) begin
            n_fail++;
            $display("FAIL req_ready_wait: got %0b want 1", dmi_if.dmi_req_ready);
            return;
        end
        dmi_if.dmi_req_valid = 1'b1;
        dmi_if.dmi_req_op    = op;
        dmi_if.dmi_req_addr  = addr;
        dmi_if.dmi_req_data  = data;
        @(posedge CLK);
        model_push(op, addr, data);
        #1;
        idle_inputs();
        n_checks++;
        if (dmi_if.dmi_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL req_ready_drop: got %0b want 0", dmi_if.dmi_req_ready);
        end
    endtask

    // Wait for the response, check latency and contents, optionally stall, then complete the handshake.
    task automatic get_rsp(input int hold, input bit pulse);
        int          k;
        logic [31:0] ed;
        logic [1:0]  er;
        k = 0;
        while (k < 64) begin
            @(posedge CLK); #1;
            k++;
            if (dmi_if.dmi_rsp_valid === 1'b1) break;
        end
        ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hXXXXXXXX;
        er = (exp_resp_q.size() > 0) ? exp_resp_q.pop_front() : 2'bXX;
        n_checks++;
        if (dmi_if.dmi_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout: got valid=%0b want 1", dmi_if.dmi_rsp_valid);
            return;
        end
        n_checks++;
        if (k !== LAT + 1) begin
            n_fail++;
            $display("FAIL rsp_latency: got %0d want %0d", k, LAT + 1);
        end
        n_checks++;
        if (dmi_if.dmi_rsp_data !== ed) begin
            n_fail++;
            $display("FAIL rsp_data: got %h want %h", dmi_if.dmi_rsp_data, ed);
        end
        n_checks++;
        if (dmi_if.dmi_rsp_response !== er) begin
            n_fail++;
            $display("FAIL rsp_response: got %0d want %0d", dmi_if.dmi_rsp_response, er);
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 3) begin
                dmi_if.dmi_req_valid = 1'b1;
                dmi_if.dmi_req_op    = 2'd2;
                dmi_if.dmi_req_addr  = 7'h05;
                dmi_if.dmi_req_data  = 32'hAAAA5555;
            end
            @(posedge CLK); #1;
            if (pulse && i == 3) idle_inputs();
            n_checks++;
            if (dmi_if.dmi_rsp_valid !== 1'b1 || dmi_if.dmi_rsp_data !== ed ||
                dmi_if.dmi_rsp_response !== er || dmi_if.dmi_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable: got v=%0b d=%h r=%0d rdy=%0b want v=1 d=%h r=%0d rdy=0",
                         dmi_if.dmi_rsp_valid, dmi_if.dmi_rsp_data, dmi_if.dmi_rsp_response,
                         dmi_if.dmi_req_ready, ed, er);
            end
        end
        dmi_if.dmi_rsp_ready = 1'b1;
        @(posedge CLK); #1;
        dmi_if.dmi_rsp_ready = 1'b0;
        n_checks++;
        if (dmi_if.dmi_rsp_valid !== 1'b0 || dmi_if.dmi_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_handshake: got v=%0b rdy=%0b want v=0 rdy=1",
                     dmi_if.dmi_rsp_valid, dmi_if.dmi_req_ready);
        end
    endtask

    task automatic transact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        do_req(op, addr, data);
        get_rsp(0, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (dmi_if.dmi_req_ready !== 1'b0 || dmi_if.dmi_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got rdy=%0b v=%0b want 0 0",
                         dmi_if.dmi_req_ready, dmi_if.dmi_rsp_valid);
            end
        end
        RST = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        n_checks++;
        if (dmi_if.dmi_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %0b want 1", dmi_if.dmi_req_ready);
        end
        transact(2'd1, 7'h05, 32'd0);
    endtask

    task automatic test_write_read();
        transact(2'd2, 7'h04, 32'hDEADBEEF);
        transact(2'd1, 7'h04, 32'd0);
        transact(2'd2, 7'h13, 32'h0BADF00D);
        transact(2'd1, 7'h13, 32'd0);
        transact(2'd1, 7'h03, 32'd0);
        transact(2'd1, 7'h14, 32'd0);
    endtask

    task automatic test_out_of_window();
        transact(2'd2, 7'h40, 32'h12345678);
        transact(2'd1, 7'h40, 32'd0);
        transact(2'd2, 7'h7F, 32'h55555555);
        transact(2'd3, 7'h04, 32'hFFFFFFFF);
        transact(2'd1, 7'h04, 32'd0);
    endtask

    task automatic test_backpressure();
        dmi_if.dmi_rsp_ready = 1'b0;
        do_req(2'd1, 7'h04, 32'd0);
        get_rsp(10, 1'b1);
        transact(2'd1, 7'h05, 32'd0);
        transact(2'd1, 7'h7F, 32'd0);
    endtask

    task automatic test_counter();
        apply_reset(2);
        transact(2'd0, 7'h00, 32'd0);
        transact(2'd2, 7'h06, 32'h00C0FFEE);
        transact(2'd1, 7'h06, 32'd0);
        transact(2'd3, 7'h10, 32'd0);
        transact(2'd0, 7'h7F, 32'd0);
        transact(2'd1, 7'h7F, 32'd0);
        transact(2'd1, 7'h7F, 32'd0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    addr = 7'($urandom_range(4, 19));
                2:       addr = 7'h7F;
                default: addr = 7'($urandom_range(0, 127));
            endcase
            data = $urandom;
            transact(op, addr, data);
        end
    endtask

    task automatic test_reset_mid_op();
        transact(2'd2, 7'h08, 32'h87654321);
        do_req(2'd1, 7'h08, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (dmi_if.dmi_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_valid: got %0b want 0", dmi_if.dmi_rsp_valid);
            end
        end
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < LAT + 4; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (dmi_if.dmi_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_rsp: got %0b want 0", dmi_if.dmi_rsp_valid);
            end
        end
        transact(2'd1, 7'h7F, 32'd0);
        transact(2'd1, 7'h08, 32'd0);
        transact(2'd1, 7'h04, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_write_read();
        test_out_of_window();
        test_backpressure();
        test_counter();
        test_random();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
